// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, responder FSM states and byte-enable helper for dmem_responder.
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    byte_en = size == SZ_BYTE ? 4'b0001 << lane : size == SZ_HALF ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store lane replication, byte enables and load extraction/extension.
// With DMEM_MISALIGN_TRAP_EN, misaligned half/word accesses get no enables and a zero load result.
module dmem_lane_align import dmem_pkg::*; (
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic [31:0] wrep,
  output logic [3:0]  be,
  output logic [31:0] rdata
);
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] ext;
  assign b = rword[{lane, 3'b000} +: 8];
  assign h = lane[1] ? rword[31:16] : rword[15:0];
  assign ext = size == SZ_BYTE ? {{24{sign & b[7]}}, b} :
               size == SZ_HALF ? {{16{sign & h[15]}}, h} : rword;
  assign wrep = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? lane[0] : lane != 2'b00;
  assign be = misalign ? 4'b0000 : byte_en(size, lane);
  assign rdata = misalign ? 32'd0 : ext;
`else
  assign be = byte_en(size, lane);
  assign rdata = ext;
`endif
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: M-stage data memory with fixed LATENCY, stall/done handshake and lane steering.
// Optional DMEM_MISALIGN_TRAP_EN adds misalign_o and suppresses misaligned accesses.
module dmem_responder import dmem_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] addr_r, wdata_r, addr_c, wdata_c, wrep, ldata;
  logic [1:0] size_r, size_c;
  logic sign_r, we_r, sign_c, we_c, idle_acc, commit;
  logic [3:0] be;
  logic [AW-1:0] idx;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis;
`endif
  // With LATENCY=1 the commit edge is the acceptance edge, so operands bypass the capture registers.
  assign idle_acc = state == IDLE && req_i;
  assign addr_c = state == IDLE ? addr_i : addr_r;
  assign wdata_c = state == IDLE ? wdata_i : wdata_r;
  assign size_c = state == IDLE ? size_i : size_r;
  assign sign_c = state == IDLE ? sign_i : sign_r;
  assign we_c = state == IDLE ? we_i : we_r;
  assign idx = AW'(addr_c[31:2]);
  assign commit = nxt == DONE;
  assign stall_o = idle_acc || state == BUSY;
  assign done_o = state == DONE;
  dmem_lane_align u_align (
    .size(size_c),
    .sign(sign_c),
    .lane(addr_c[1:0]),
    .wdata(wdata_c),
    .rword(mem[idx]),
`ifdef DMEM_MISALIGN_TRAP_EN
    .misalign(mis),
`endif
    .wrep(wrep),
    .be(be),
    .rdata(ldata)
  );
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    nxt = idle_acc ? (LATENCY == 1 ? DONE : BUSY) :
          state == BUSY ? (cnt <= CW'(1) ? DONE : BUSY) : IDLE;
    cnt_nxt = idle_acc ? CW'(LATENCY - 1) : state == BUSY ? cnt - 1'b1 : cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rdata_o <= '0;
      addr_r <= '0;
      wdata_r <= '0;
      size_r <= '0;
      sign_r <= 1'b0;
      we_r <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      if (idle_acc) begin
        addr_r <= addr_i;
        wdata_r <= wdata_i;
        size_r <= size_i;
        sign_r <= sign_i;
        we_r <= we_i;
      end
      if (commit && !we_c) rdata_o <= ldata;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign_o <= commit && mis;
`endif
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (!rst && commit && we_c && be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (LATENCY=2, DEPTH_WORDS=1024).
module tb_dmem_responder;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst, req, we, sign;
  logic [1:0] size;
  logic [31:0] addr, wdata, rdata;
  logic stall, done;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign;
`endif
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exp_q [$];
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req),
    .we_i(we),
    .size_i(size),
    .sign_i(sign),
    .addr_i(addr),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .stall_o(stall),
    .done_o(done)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .misalign_o(misalign)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Loads push their expected result when issued and pop it at done_o.
  task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp,
                        input logic chk_timing);
    int cyc, stalls;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign = sg; addr = a; wdata = d;
    if (!w) exp_q.push_back(exp);
    cyc = 0;
    stalls = 0;
    forever begin
      #1;
      if (done || cyc > 20) break;
      if (stall) stalls++;
      cyc++;
      @(negedge clk);
      req = 1'b0;
    end
    req = 1'b0;
    check({tag, ".done"}, {31'd0, done}, 32'd1);
    if (chk_timing) begin
      check({tag, ".lat"}, cyc, LAT);
      check({tag, ".stalls"}, stalls, LAT);
      check({tag, ".stall_in_done"}, {31'd0, stall}, 32'd0);
    end
    if (!w && exp_q.size() > 0) check({tag, ".rdata"}, rdata, exp_q.pop_front());
  endtask
  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sign = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst.rdata", rdata, 32'd0);
    check("rst.stall", {31'd0, stall}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    access("sw10", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 1);
    access("lw10", 0, 2'd2, 0, 32'h10, 0, 32'hDEADBEEF, 1);
    @(negedge clk);
    #1;
    check("idle.done", {31'd0, done}, 32'd0);
    access("sw10z", 1, 2'd2, 0, 32'h10, 32'h0, 0, 0);
    check("store_keeps_rdata", rdata, 32'hDEADBEEF);
    access("sb13", 1, 2'd0, 0, 32'h13, 32'h000000A5, 0, 0);
    access("lw10b", 0, 2'd2, 0, 32'h10, 0, 32'hA5000000, 0);
    access("lb13", 0, 2'd0, 1, 32'h13, 0, 32'hFFFFFFA5, 0);
    access("lbu13", 0, 2'd0, 0, 32'h13, 0, 32'h000000A5, 0);
    access("sw20z", 1, 2'd2, 0, 32'h20, 32'h0, 0, 0);
    access("sh22", 1, 2'd1, 0, 32'h22, 32'h00008001, 0, 1);
    access("lh22", 0, 2'd1, 1, 32'h22, 0, 32'hFFFF8001, 0);
    access("lhu22", 0, 2'd1, 0, 32'h22, 0, 32'h00008001, 0);
    access("lw20", 0, 2'd2, 0, 32'h20, 0, 32'h80010000, 0);
    access("sw1004", 1, 2'd2, 0, 32'h1004, 32'h12345678, 0, 0);
    access("lw4_wrap", 0, 2'd2, 0, 32'h4, 0, 32'h12345678, 0);
    access("sw40", 1, 2'd2, 0, 32'h40, 32'h11223344, 0, 0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h40; wdata = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("abort.stall", {31'd0, stall}, 32'd0);
    check("abort.done", {31'd0, done}, 32'd0);
    check("abort.rdata", rdata, 32'd0);
    rst = 1'b0;
    access("lw40_abort", 0, 2'd2, 0, 32'h40, 0, 32'h11223344, 1);
    access("sw41", 1, 2'd2, 0, 32'h41, 32'hAABBCCDD, 0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("sw41.misalign", {31'd0, misalign}, 32'd1);
    access("lw40_mis", 0, 2'd2, 0, 32'h40, 0, 32'h11223344, 0);
    check("lw40.misalign", {31'd0, misalign}, 32'd0);
`else
    access("lw40_mis", 0, 2'd2, 0, 32'h40, 0, 32'hAABBCCDD, 0);
`endif
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the M stage of the five-stage MIPS pipeline; it is the far end of the load/store interface driven by the datapath.
- Accepts one load or store per request, models a synchronous SRAM with fixed multi-cycle latency, and performs byte-lane steering on stores and sign/zero extension on loads.
- Raises a stall to the hazard unit while an access is in flight.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the internal array; must be a power of 2.
- LATENCY, 2: cycles from request acceptance to data/completion; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_i  in  1  M-stage memory access valid.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
- sign_i  in  1  load sign-extends when 1, zero-extends when 0.
- addr_i  in  32  byte address (aluoutM).
- wdata_i  in  32  store data (writedataM); value is in the low bits.
- rdata_o  out  32  extended load result (readdataM).
- stall_o  out  1  freezes F..W while the access is pending.
- done_o  out  1  one-cycle completion pulse.
- misalign_o  out  1  present only with the optional feature.

Behaviour:
- Reset: state IDLE, counter 0, rdata_o 0, done_o 0, stall_o 0, misalign_o 0.
- Reset asserted mid-access aborts the access. A store not yet committed is discarded.
- FSM states: IDLE, BUSY, DONE.
- IDLE with req_i=1 (cycle T):
  - capture addr, wdata, size, sign, we;
  - stall_o=1 combinationally in cycle T;
  - load counter with LATENCY-1;
  - next state is BUSY, or DONE when LATENCY=1.
- BUSY: stall_o=1; counter decrements; when counter=0 at the edge, go to DONE.
- Store commit: the array write happens on the edge entering DONE.
- DONE (cycle T+LATENCY):
  - stall_o=0 and done_o=1;
  - rdata_o is registered and valid from this cycle; it holds until the next load completes;
  - req_i is ignored, because it is still the completing request;
  - next state is IDLE.
- Back-to-back accesses: each access costs LATENCY stall cycles. A new request is sampled in the IDLE cycle after DONE.
- Address mapping: word index = addr[log2(DEPTH_WORDS)+1:2]; upper bits ignored, so the address wraps modulo the array size.
- Little-endian lane order:
  - byte lane = addr[1:0];
  - half lane = addr[1];
  - store byte/half data is replicated across lanes; only the selected byte enables write.
- Load: select lane, then sign- or zero-extend to 32 bits. Stores leave rdata_o unchanged.
- Misaligned access without the feature: low address bits below the access size are ignored (half uses addr[1], word uses none).

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - misalign_o is asserted in the DONE cycle for a half access with addr[0]=1 or a word access with addr[1:0]!=0;
  - a misaligned store is suppressed (no byte enables);
  - a misaligned load returns rdata_o=0.
- Undefined: port absent; low-bit masking as above.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state enum;
  - the byte-enable function.
- Sub-module dmem_lane_align (combinational) holds store lane replication, byte-enable generation, and load extraction/extension. The responder keeps the FSM, counter, array and registers.

Test Plan:
- Word store then word load, LATENCY=2, addr 0x10, data 0xDEADBEEF:
  - stall high 2 cycles per access;
  - done in 3rd cycle;
  - rdata_o=0xDEADBEEF.
- Byte store 0xA5 to 0x13 over word 0x00000000:
  - load word returns 0xA5000000;
  - lb 0x13 returns 0xFFFFFFA5;
  - lbu 0x13 returns 0x000000A5.
- Half store 0x8001 to 0x22:
  - lh 0x22 returns 0xFFFF8001;
  - lhu 0x22 returns 0x00008001;
  - lw 0x20 has upper half 0x8001.
- Address wrap, DEPTH_WORDS=1024: store to 0x1004 then load 0x0004 returns the stored value.
- rst asserted in BUSY of a store to 0x40:
  - FSM returns to IDLE, stall_o=0;
  - later load 0x40 returns prior contents.
- With DMEM_MISALIGN_TRAP_EN, sw to 0x41:
  - misalign_o=1 in DONE;
  - word 0x40 unchanged.
  - Without the macro, the same store writes word 0x40.
